// File: rtl/photon_pkg.sv
// Shared types and constants for the photon window sampler.
// FSM state encoding, drop counter width and default count width.
package photon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DROP_W        = 16;
    localparam int COUNTSIZE_DEF = 32;

endpackage

// File: rtl/photon_win_fifo.sv
// First-word-fall-through FIFO for window deltas.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module photon_win_fifo #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic [W-1:0]  r_last;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL_LVL);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_cnt;
    // Head is shown straight from storage; when empty the last popped word is held.
    assign o_dout  = w_empty ? r_last : r_mem[r_rd];

    // Storage write; contents are only visible once counted, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointer, occupancy and last-popped-word bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_last <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= r_mem[r_rd];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/photon_window_sampler.sv
// Samples a running photon count at fixed window boundaries and queues per-window deltas.
// Optional macro PHOTON_WIN_THRESH_EN adds g_thresh / g_above threshold flag.
module photon_window_sampler
    import photon_pkg::*;
#(
    parameter int COUNTSIZE = COUNTSIZE_DEF,
    parameter int WINSIZE   = 24,
    parameter int FIFO_AW   = 3
) (
    input  logic                 g_clk,
    input  logic                 g_rst_n,
    input  logic                 g_en,
    input  logic [WINSIZE-1:0]   g_win_len,
    input  logic [COUNTSIZE-1:0] g_photon_cnt,
    output logic [COUNTSIZE-1:0] g_win_data,
    output logic                 g_win_valid,
    input  logic                 g_win_ready,
    output logic [FIFO_AW:0]     g_fifo_level,
    output logic [DROP_W-1:0]    g_drop_cnt
`ifdef PHOTON_WIN_THRESH_EN
    ,
    input  logic [COUNTSIZE-1:0] g_thresh,
    output logic                 g_above
`endif
);

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [WINSIZE-1:0]     r_timer;
    logic [WINSIZE-1:0]     w_timer_nx;
    logic [COUNTSIZE-1:0]   r_base;
    logic [COUNTSIZE-1:0]   w_base_nx;
    logic [DROP_W-1:0]      r_drop_cnt;

    logic [WINSIZE-1:0]     w_reload;
    logic [COUNTSIZE-1:0]   w_delta;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;

    // A zero length behaves like a one-clock window.
    assign w_reload = (g_win_len == '0) ? '0 : g_win_len - 1'b1;
    // Modular subtraction keeps the delta right across counter wrap.
    assign w_delta  = g_photon_cnt - r_base;

    assign w_pop  = !w_empty && g_win_ready;
    assign w_drop = w_push && w_full && !w_pop;

    assign g_win_valid = !w_empty;
    assign g_drop_cnt  = r_drop_cnt;

    // State, timer and baseline registers.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_base  <= w_base_nx;
        end
    end

    // Next-state logic: arm on enable, count down, push a delta at each boundary.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_base_nx  = r_base;
        w_push     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (g_en) begin
                    w_state_nx = RUN;
                    w_base_nx  = g_photon_cnt;
                    w_timer_nx = w_reload;
                end
            end
            RUN: begin
                if (!g_en) begin
                    w_state_nx = IDLE;
                end else if (r_timer == '0) begin
                    w_push     = 1'b1;
                    w_base_nx  = g_photon_cnt;
                    w_timer_nx = w_reload;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Saturating count of windows lost to a full FIFO.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

`ifdef PHOTON_WIN_THRESH_EN
    logic r_above;
    assign g_above = r_above;

    // Threshold flag updated at every boundary, cleared when sampling stops.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_above <= 1'b0;
        end else if (w_push) begin
            r_above <= (w_delta >= g_thresh);
        end else if (r_state == RUN && !g_en) begin
            r_above <= 1'b0;
        end
    end
`endif

    photon_win_fifo #(
        .W  (COUNTSIZE),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (g_clk),
        .i_rst_n (g_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_delta),
        .o_dout  (g_win_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (g_fifo_level)
    );

endmodule

// File: doc/photon_window_sampler.md
# photon_window_sampler

Downstream of the photon counter: samples the free-running cumulative count `g_photon_cnt` at fixed window boundaries and emits per-window photon deltas. Deltas are buffered in a small FIFO behind a valid/ready stream toward the readout/host interface. This turns a raw running total into a time-binned count-rate series for motion analysis.

## Interface
- `COUNTSIZE`, 32, width of the input count and of each window delta
- `WINSIZE`, 24, width of the window-length register/timer
- `FIFO_AW`, 3, FIFO address width; depth = 2^FIFO_AW
- `g_clk`  in  1  sole clock; all logic on rising edge
- `g_rst_n`  in  1  asynchronous, active-low reset
- `g_en`  in  1  sampling enable
- `g_win_len`  in  WINSIZE  window length in clocks; 0 treated as 1
- `g_photon_cnt`  in  COUNTSIZE  cumulative count from the photon counter, same clock domain
- `g_win_data`  out  COUNTSIZE  FIFO head: photons in one window
- `g_win_valid`  out  1  FIFO non-empty
- `g_win_ready`  in  1  consumer accepts head when high with valid
- `g_fifo_level`  out  FIFO_AW+1  current FIFO occupancy
- `g_drop_cnt`  out  16  windows lost to FIFO full; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN.
- IDLE: timer held; no pushes. When `g_en`=1: baseline <= `g_photon_cnt`, timer <= max(`g_win_len`,1)-1, go RUN.
- RUN, timer != 0: timer decrements each clock.
- RUN, timer == 0 (boundary): delta = `g_photon_cnt` - baseline, modulo 2^COUNTSIZE, so counter wrap yields the correct delta; baseline <= `g_photon_cnt`; timer <= max(`g_win_len`,1)-1. `g_win_len` is sampled only at arm and at boundaries; mid-window changes apply to the next window.
- Push delta into FIFO at boundary. If full and no pop in the same cycle: delta discarded, `g_drop_cnt` increments (saturating). Full with a simultaneous pop: push accepted, level unchanged.
- RUN with `g_en`=0: partial window discarded, no push, go IDLE. FIFO contents retained.
- Pop when `g_win_valid` && `g_win_ready`. FIFO is first-word-fall-through: `g_win_data` is the head whenever valid. When empty, `g_win_data` holds its last value; it has no meaning while invalid.
- Once high, `g_win_valid` stays high until a pop empties the FIFO.
- `g_drop_cnt` clears only on reset.
- Reset (any time, including mid-window): state IDLE, timer/baseline 0, FIFO empty, `g_win_valid`=0, `g_win_data`=0, `g_fifo_level`=0, `g_drop_cnt`=0.

## Timing
- Window period is exactly max(`g_win_len`,1) clocks.
- First boundary occurs max(L,1) clocks after the arming edge.
- Delta is captured on the boundary edge. `g_win_valid` rises on that edge if the FIFO was empty, i.e. it is seen high in the following cycle.
- Count latency: a `g_photon_cnt` increment visible before the boundary edge belongs to the window ending there.
- Pop takes effect on the edge where valid && ready. The next head is presented in the following cycle, with no bubble.

## Configuration
- `PHOTON_WIN_THRESH_EN` defined: adds input `g_thresh` [COUNTSIZE-1:0] and output `g_above` (1 bit). At each boundary, `g_above` <= (delta >= `g_thresh`), independent of FIFO full or drop. It holds until the next boundary, resets to 0, and clears to 0 on return to IDLE.
- Not defined: the port and logic are absent; all other behaviour is identical.

## Structure
- Package `photon_pkg`: FSM state enum (IDLE, RUN), `DROP_W`=16, default `COUNTSIZE`.
- Sub-module `photon_win_fifo`: synchronous FWFT FIFO, parameterised by width and FIFO_AW. It provides push/pop/full/empty/level and implements the full-with-simultaneous-pop acceptance rule.

## Test plan
- Steady rate: L=10, count increments every 2nd clock, consumer always ready → stream of deltas equal to 5; `g_drop_cnt`=0.
- Wrap: baseline 32'hFFFF_FFFE, +5 counts within the window → delta = 5.
- Backpressure: ready=0, L=4, FIFO_AW=3 → level reaches 8; the next two windows are dropped (`g_drop_cnt`=2). Then ready=1 → the 8 stored deltas drain in order, one per clock.
- Full with simultaneous pop at a boundary → push accepted, level stays 8, `g_drop_cnt` unchanged.
- Disable and reset: deassert `g_en` mid-window → no push, FIFO retained. Assert `g_rst_n`=0 mid-window → all outputs 0 and FIFO empty. Test `g_win_len`=0 → a delta every clock.
- With `PHOTON_WIN_THRESH_EN`, thresh=5: deltas 4, 5, 6 → `g_above` = 0, 1, 1.
